// File: rtl/pcm_stream_framer_pkg.sv
// Shared types and sizing helpers for the PCM stream framer and its frame FIFO.
package pcm_pkg;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_PLAY  = 1'b1
    } play_state_e;

    function automatic int frame_bits(input int channels, input int sample_bits);
        return channels * sample_bits;
    endfunction

    function automatic int bytes_per_sample(input int sample_bits);
        return sample_bits / 8;
    endfunction

    // Counter width that stays at least one bit for single-value ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcm_frame_fifo.sv
// Single-clock frame FIFO with registered RAM read, full/empty flags and fill count.
module pcm_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire, rd_fire;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (MSBs equal).
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign fill_o  = wr_ptr_q - rd_ptr_q;

    assign wr_fire  = wr_en_i && !full_o;
    assign rd_fire  = rd_en_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
        if (rd_fire) begin
            rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pcm_stream_framer.sv
// Assembles a little-endian byte stream into N-channel PCM frames, buffers them,
// and plays one frame per sample enable with priming, flow control and resync.
module pcm_stream_framer
    import pcm_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int SAMPLE_BITS   = 16,
    parameter int FIFO_DEPTH    = 4096,
    parameter int LOW_WATER     = 1228,
    parameter int HIGH_WATER    = 2048,
    parameter int SYNC_TIMEOUT  = 4096,
    parameter int UNDERRUN_HOLD = 0
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [7:0]                            rx_data_i,
    input  logic                                  received_i,
    input  logic                                  sample_ce_i,
    output logic [CHANNELS*SAMPLE_BITS-1:0]       samples_o,
    output logic                                  out_valid_o,
    output logic                                  cts_o,
    output logic [$clog2(FIFO_DEPTH):0]           fill_o,
    output logic                                  underrun_o,
    output logic                                  overflow_o,
    output logic                                  resync_o
);
    localparam int BYTES      = bytes_per_sample(SAMPLE_BITS);
    localparam int FRAME_BITS = frame_bits(CHANNELS, SAMPLE_BITS);
    localparam int BYTE_W     = idx_width(BYTES);
    localparam int CHAN_W     = idx_width(CHANNELS);
    localparam int FILL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int OFF_W      = $clog2(FRAME_BITS);
    localparam int IDLE_W     = $clog2(SYNC_TIMEOUT + 1);

    localparam logic [FILL_W-1:0] LOW_LVL  = FILL_W'(LOW_WATER);
    localparam logic [FILL_W-1:0] HIGH_LVL = FILL_W'(HIGH_WATER);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SYNC_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_TRIP = IDLE_W'(SYNC_TIMEOUT - 1);

    logic [BYTE_W-1:0]     byte_idx_q, byte_idx_d;
    logic [CHAN_W-1:0]     chan_idx_q, chan_idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  resync_q, resync_d;
    logic                  overflow_q, overflow_d;
    logic [OFF_W-1:0]      wr_off;
    logic                  partial;

    play_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] samples_q, samples_d;
    logic                  out_valid_q, out_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  load_q, load_d;
    logic                  cts_q, cts_d;

    logic                  fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [FRAME_BITS-1:0] fifo_rd_data;
    logic [FILL_W-1:0]     fifo_fill;

    pcm_frame_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (fifo_wr),
        .wr_data_i (frame_d),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .fill_o    (fifo_fill)
    );

    // Channel 0 occupies the MSB slice; bytes fill each slice from its LSB up.
    assign wr_off  = OFF_W'((CHANNELS - 1 - int'(chan_idx_q)) * SAMPLE_BITS + int'(byte_idx_q) * 8);
    assign partial = (byte_idx_q != '0) || (chan_idx_q != '0);

    always_comb begin
        frame_d    = frame_q;
        byte_idx_d = byte_idx_q;
        chan_idx_d = chan_idx_q;
        idle_d     = idle_q;
        resync_d   = 1'b0;
        overflow_d = 1'b0;
        fifo_wr    = 1'b0;
        if (received_i) begin
            frame_d[wr_off +: 8] = rx_data_i;
            idle_d = '0;
            if (byte_idx_q == LAST_BYTE) begin
                byte_idx_d = '0;
                if (chan_idx_q == LAST_CHAN) begin
                    chan_idx_d = '0;
                    fifo_wr    = 1'b1;
                    overflow_d = fifo_full;
                end else begin
                    chan_idx_d = chan_idx_q + 1'b1;
                end
            end else begin
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end else begin
            if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + 1'b1;
            end
            if (partial && (idle_q == IDLE_TRIP)) begin
                byte_idx_d = '0;
                chan_idx_d = '0;
                resync_d   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        samples_d   = samples_q;
        out_valid_d = out_valid_q;
        underrun_d  = 1'b0;
        load_d      = 1'b0;
        fifo_rd     = 1'b0;
        // Popped data emerges from the RAM one cycle after the read strobe.
        if (load_q) begin
            samples_d = fifo_rd_data;
        end
        case (state_q)
            ST_PRIME: begin
                if (fifo_fill >= LOW_LVL) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (sample_ce_i) begin
                    if (!fifo_empty) begin
                        fifo_rd     = 1'b1;
                        load_d      = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        underrun_d  = 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = ST_PRIME;
                        if (UNDERRUN_HOLD == 0) begin
                            samples_d = '0;
                        end
                    end
                end
            end
            default: state_d = ST_PRIME;
        endcase
    end

    // Hysteresis: between the two water marks cts keeps its previous value.
    always_comb begin
        cts_d = cts_q;
        if (fifo_fill >= HIGH_LVL) begin
            cts_d = 1'b0;
        end else if (fifo_fill <= LOW_LVL) begin
            cts_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            byte_idx_q  <= '0;
            chan_idx_q  <= '0;
            frame_q     <= '0;
            idle_q      <= '0;
            resync_q    <= 1'b0;
            overflow_q  <= 1'b0;
            state_q     <= ST_PRIME;
            samples_q   <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            load_q      <= 1'b0;
            cts_q       <= 1'b1;
        end else begin
            byte_idx_q  <= byte_idx_d;
            chan_idx_q  <= chan_idx_d;
            frame_q     <= frame_d;
            idle_q      <= idle_d;
            resync_q    <= resync_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            samples_q   <= samples_d;
            out_valid_q <= out_valid_d;
            underrun_q  <= underrun_d;
            load_q      <= load_d;
            cts_q       <= cts_d;
        end
    end

    assign samples_o   = samples_q;
    assign out_valid_o = out_valid_q;
    assign cts_o       = cts_q;
    assign fill_o      = fifo_fill;
    assign underrun_o  = underrun_q;
    assign overflow_o  = overflow_q;
    assign resync_o    = resync_q;

endmodule

// File: tb/tb_pcm_stream_framer.sv
// Directed bench: stereo 16-bit instances (zero and hold underrun) plus a 3x24-bit instance.
module tb_pcm_stream_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  rx_data;
    logic        received, sample_ce, received_c, sample_ce_c;

    logic [31:0] samples_a, samples_b;
    logic [71:0] samples_c;
    logic        out_valid_a, cts_a, underrun_a, overflow_a, resync_a;
    logic        out_valid_b, cts_b, underrun_b, overflow_b, resync_b;
    logic        out_valid_c, cts_c, underrun_c, overflow_c, resync_c;
    logic [2:0]  fill_a, fill_b, fill_c;

    int checks = 0;
    int failures = 0;

    pcm_stream_framer #(.CHANNELS(2), .SAMPLE_BITS(16), .FIFO_DEPTH(4), .LOW_WATER(2),
        .HIGH_WATER(3), .SYNC_TIMEOUT(16), .UNDERRUN_HOLD(0)) dut_a (
        .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .received_i(received),
        .sample_ce_i(sample_ce), .samples_o(samples_a), .out_valid_o(out_valid_a),
        .cts_o(cts_a), .fill_o(fill_a), .underrun_o(underrun_a), .overflow_o(overflow_a),
        .resync_o(resync_a));

    pcm_stream_framer #(.CHANNELS(2), .SAMPLE_BITS(16), .FIFO_DEPTH(4), .LOW_WATER(2),
        .HIGH_WATER(3), .SYNC_TIMEOUT(16), .UNDERRUN_HOLD(1)) dut_b (
        .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .received_i(received),
        .sample_ce_i(sample_ce), .samples_o(samples_b), .out_valid_o(out_valid_b),
        .cts_o(cts_b), .fill_o(fill_b), .underrun_o(underrun_b), .overflow_o(overflow_b),
        .resync_o(resync_b));

    pcm_stream_framer #(.CHANNELS(3), .SAMPLE_BITS(24), .FIFO_DEPTH(4), .LOW_WATER(2),
        .HIGH_WATER(3), .SYNC_TIMEOUT(16), .UNDERRUN_HOLD(0)) dut_c (
        .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .received_i(received_c),
        .sample_ce_i(sample_ce_c), .samples_o(samples_c), .out_valid_o(out_valid_c),
        .cts_o(cts_c), .fill_o(fill_c), .underrun_o(underrun_c), .overflow_o(overflow_c),
        .resync_o(resync_c));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        received = 1'b1;
        tick(1);
        received = 1'b0;
    endtask

    task automatic send_byte_c(input logic [7:0] b);
        rx_data    = b;
        received_c = 1'b1;
        tick(1);
        received_c = 1'b0;
    endtask

    // Channel 0 = v[31:16], channel 1 = v[15:0], each LSB byte first.
    task automatic send_frame(input logic [31:0] v);
        send_byte(v[23:16]);
        send_byte(v[31:24]);
        send_byte(v[7:0]);
        send_byte(v[15:8]);
        $display("tx frame %08h fill=%0d cts=%0b", v, fill_a, cts_a);
    endtask

    task automatic pulse_ce;
        sample_ce = 1'b1;
        tick(1);
        sample_ce = 1'b0;
        $display("sample_ce samples=%08h out_valid=%0b fill=%0d", samples_a, out_valid_a, fill_a);
    endtask

    int rs_count;
    int rs_first;

    initial begin
        reset = 1'b1; rx_data = 8'h00; received = 1'b0; sample_ce = 1'b0;
        received_c = 1'b0; sample_ce_c = 1'b0;
        tick(3);
        chk("rst_samples", samples_a, 32'h0);
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_cts", cts_a, 1'b1);
        chk("rst_fill", fill_a, 3'd0);
        chk("rst_pulses", {underrun_a, overflow_a, resync_a}, 3'b000);
        reset = 1'b0;
        tick(1);

        // Basic framing and first playout
        send_frame(32'h1234_5678);
        chk("wr_latency_fill1", fill_a, 3'd1);
        send_frame(32'h1122_3344);
        chk("fill2", fill_a, 3'd2);
        tick(1);
        chk("cts_at_low", cts_a, 1'b1);
        pulse_ce;
        chk("play_valid", out_valid_a, 1'b1);
        chk("pop_fill1", fill_a, 3'd1);
        tick(2);
        chk("play_samples1", samples_a, 32'h1234_5678);
        tick(1);
        pulse_ce;
        tick(3);
        chk("play_samples2", samples_a, 32'h1122_3344);
        chk("pop_fill0", fill_a, 3'd0);

        // Underrun: zero policy on A, hold policy on B
        pulse_ce;
        chk("underrun_pulse", underrun_a, 1'b1);
        chk("underrun_valid", out_valid_a, 1'b0);
        chk("underrun_zero", samples_a, 32'h0);
        chk("underrun_hold_pulse", underrun_b, 1'b1);
        chk("underrun_hold", samples_b, 32'h1122_3344);
        tick(1);
        chk("underrun_one_cycle", underrun_a, 1'b0);
        tick(2);

        // Overflow and flow control
        send_frame(32'h1000_0001);
        send_frame(32'h2000_0002);
        send_frame(32'h3000_0003);
        chk("ovf_fill3", fill_a, 3'd3);
        chk("cts_registered", cts_a, 1'b1);
        tick(1);
        chk("cts_fall", cts_a, 1'b0);
        send_frame(32'h4000_0004);
        chk("ovf_fill4", fill_a, 3'd4);
        send_frame(32'h5000_0005);
        chk("overflow_pulse", overflow_a, 1'b1);
        chk("overflow_fill", fill_a, 3'd4);
        tick(1);
        chk("overflow_one_cycle", overflow_a, 1'b0);
        pulse_ce;
        chk("drain_fill3", fill_a, 3'd3);
        tick(3);
        chk("drain_g1", samples_a, 32'h1000_0001);
        chk("cts_hold_mid", cts_a, 1'b0);
        pulse_ce;
        chk("drain_fill2", fill_a, 3'd2);
        tick(1);
        chk("cts_rise", cts_a, 1'b1);
        tick(2);
        chk("drain_g2", samples_a, 32'h2000_0002);

        // Simultaneous write and pop
        send_byte(8'h00);
        send_byte(8'h60);
        send_byte(8'h06);
        rx_data = 8'h00; received = 1'b1; sample_ce = 1'b1;
        tick(1);
        received = 1'b0; sample_ce = 1'b0;
        chk("simul_fill", fill_a, 3'd2);
        tick(3);
        chk("simul_g3", samples_a, 32'h3000_0003);

        // Resync after a partial frame
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'h55);
        rs_count = 0;
        rs_first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (resync_a) begin
                rs_count++;
                if (rs_first == 0) rs_first = i;
            end
        end
        chk("resync_count", rs_count, 1);
        chk("resync_cycle", rs_first, 16);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk("resync_fill3", fill_a, 3'd3);
        pulse_ce;
        tick(3);
        chk("order_g4", samples_a, 32'h4000_0004);
        pulse_ce;
        tick(3);
        chk("order_g6", samples_a, 32'h6000_0006);
        pulse_ce;
        tick(3);
        chk("resync_frame", samples_a, 32'hBBAA_DDCC);
        chk("resync_fill0", fill_a, 3'd0);

        // Three channels of 24 bits
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 9; k++) send_byte_c(8'(k));
        end
        chk("c_fill2", fill_c, 3'd2);
        tick(1);
        sample_ce_c = 1'b1;
        tick(1);
        sample_ce_c = 1'b0;
        chk("c_valid", out_valid_c, 1'b1);
        tick(3);
        chk("c_samples", samples_c, 72'h030201_060504_090807);

        // Asynchronous reset mid-frame
        send_byte(8'h77);
        send_byte(8'h77);
        reset = 1'b1;
        #1;
        chk("arst_samples", samples_a, 32'h0);
        chk("arst_valid", out_valid_a, 1'b0);
        chk("arst_fill", fill_a, 3'd0);
        chk("arst_cts", cts_a, 1'b1);
        chk("arst_samples_c", samples_c, 72'h0);
        tick(2);
        reset = 1'b0;
        tick(1);
        send_frame(32'hCAFE_BEEF);
        send_frame(32'h0BAD_F00D);
        chk("post_rst_fill", fill_a, 3'd2);
        tick(1);
        pulse_ce;
        tick(3);
        chk("post_rst_frame", samples_a, 32'hCAFE_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
